// File: rtl/toll_booth_ctrl.sv
// Toll-lane controller: accumulates coin credit, returns excess as nickel pulses,
// opens the gate until a car passes or the gate timer expires, and flags gate runners.
module toll_booth_ctrl #(
  parameter int TOLL_CENTS   = 35,
  parameter int CREDIT_W     = 7,
  parameter int GATE_TIMEOUT = 16,
  parameter int TMR_W        = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                N1,
  input  logic                N2,
  input  logic                D,
  input  logic                Q,
  input  logic                car_pass,
  output logic [CREDIT_W-1:0] credit,
  output logic                Paid,
  output logic                Stop,
  output logic                change_nickel,
  output logic                coin_reject,
  output logic                violation
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHANGE  = 2'd2,
    PAID    = 2'd3
  } state_t;

  localparam logic [CREDIT_W-1:0] TOLL     = CREDIT_W'(TOLL_CENTS);
  localparam logic [CREDIT_W-1:0] NICKEL   = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] DIME     = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] QUARTER  = CREDIT_W'(25);
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(GATE_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] excess_q, excess_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                paid_q, paid_d;
  logic                stop_q, stop_d;
  logic                change_nickel_q, change_nickel_d;
  logic                coin_reject_q, coin_reject_d;
  logic                violation_q, violation_d;
  logic [CREDIT_W-1:0] coin_sum_s;
  logic [CREDIT_W-1:0] credit_n_s;
  logic                coin_seen_s;

  always_comb begin
    coin_sum_s  = ({CREDIT_W{N1}} & NICKEL) + ({CREDIT_W{N2}} & NICKEL)
                + ({CREDIT_W{D}} & DIME) + ({CREDIT_W{Q}} & QUARTER);
    credit_n_s  = credit_q + coin_sum_s;
    coin_seen_s = (coin_sum_s != {CREDIT_W{1'b0}});
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    excess_d = excess_q;
    timer_d  = timer_q;
    case (state_q)
      IDLE, COLLECT: begin
        if (coin_seen_s) begin
          credit_d = credit_n_s;
          if (credit_n_s < TOLL) begin
            state_d = COLLECT;
          end else if (credit_n_s == TOLL) begin
            state_d = PAID;
            timer_d = {TMR_W{1'b0}};
          end else begin
            state_d  = CHANGE;
            excess_d = credit_n_s - TOLL;
          end
        end else begin
          state_d = state_q;
        end
      end
      CHANGE: begin
        // Last nickel goes out on the cycle excess reaches 5; <= guards a corrupted excess.
        if (excess_q <= NICKEL) begin
          state_d  = PAID;
          excess_d = {CREDIT_W{1'b0}};
          timer_d  = {TMR_W{1'b0}};
        end else begin
          excess_d = excess_q - NICKEL;
        end
      end
      PAID: begin
        if (car_pass || (timer_q == TMR_LAST)) begin
          state_d  = IDLE;
          credit_d = {CREDIT_W{1'b0}};
          timer_d  = {TMR_W{1'b0}};
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = {CREDIT_W{1'b0}};
        excess_d = {CREDIT_W{1'b0}};
        timer_d  = {TMR_W{1'b0}};
      end
    endcase

    // Outputs follow the next state so they are valid on the same edge as the transition.
    paid_d          = (state_d == PAID);
    stop_d          = ~paid_d;
    change_nickel_d = (state_d == CHANGE);
    coin_reject_d   = coin_seen_s && ((state_q == CHANGE) || (state_q == PAID));
    violation_d     = car_pass && stop_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      credit_q        <= {CREDIT_W{1'b0}};
      excess_q        <= {CREDIT_W{1'b0}};
      timer_q         <= {TMR_W{1'b0}};
      paid_q          <= 1'b0;
      stop_q          <= 1'b1;
      change_nickel_q <= 1'b0;
      coin_reject_q   <= 1'b0;
      violation_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      excess_q        <= excess_d;
      timer_q         <= timer_d;
      paid_q          <= paid_d;
      stop_q          <= stop_d;
      change_nickel_q <= change_nickel_d;
      coin_reject_q   <= coin_reject_d;
      violation_q     <= violation_d;
    end
  end

  assign credit        = credit_q;
  assign Paid          = paid_q;
  assign Stop          = stop_q;
  assign change_nickel = change_nickel_q;
  assign coin_reject   = coin_reject_q;
  assign violation     = violation_q;

endmodule
